// File: rtl/node_sequencer.sv
// Control sequencer for one neural-network node accumulator: clears it, walks the input index,
// captures the activated output and offers it downstream over a valid/ready handshake.
module node_sequencer #(
  parameter int unsigned IMAGE_SIZE = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic             start_o,
  output logic             reset_acc_o,
  output logic [CNT_W-1:0] cnt_val_o,
  input  logic [15:0]      node_out_i,
  output logic [15:0]      result_o,
  output logic             result_valid_o,
  input  logic             result_ready_i,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(IMAGE_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StClear, StAccum, StCapture, StOut} state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic             start_q;
  logic             reset_acc_q;
  logic [CNT_W-1:0] cnt_val_q;
  logic [15:0]      result_q;
  logic             result_valid_q;
  logic             busy_q;

  // Every output is written together with the state it belongs to, so all of them are registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= StIdle;
      req_ready_q    <= 1'b1;
      start_q        <= 1'b1;
      reset_acc_q    <= 1'b0;
      cnt_val_q      <= '0;
      result_q       <= 16'h0000;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            state_q     <= StClear;
            req_ready_q <= 1'b0;
            reset_acc_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StClear: begin
          state_q     <= StAccum;
          reset_acc_q <= 1'b0;
          start_q     <= 1'b0;
          cnt_val_q   <= '0;
        end
        StAccum: begin
          if (cnt_val_q == CntLast) begin
            state_q   <= StCapture;
            start_q   <= 1'b1;
            cnt_val_q <= '0;
          end else begin
            cnt_val_q <= cnt_val_q + CNT_W'(1);
          end
        end
        StCapture: begin
          // The node's last accumulation landed at the edge that entered this state.
          state_q        <= StOut;
          result_q       <= node_out_i;
          result_valid_q <= 1'b1;
        end
        StOut: begin
          if (result_ready_i) begin
            state_q        <= StIdle;
            result_valid_q <= 1'b0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q        <= StIdle;
          req_ready_q    <= 1'b1;
          start_q        <= 1'b1;
          reset_acc_q    <= 1'b0;
          cnt_val_q      <= '0;
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign start_o        = start_q;
  assign reset_acc_o    = reset_acc_q;
  assign cnt_val_o      = cnt_val_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign busy_o         = busy_q;

endmodule
